lcd_bus_rx: RTL and testbench
=============================

Name: lcd_bus_rx

Overview:
- Receive-side model of the HD44780-style parallel LCD bus (en/rs/wr/data[7:0]) that our LCD controller drives.
- Snoops the pins and decodes each en falling-edge strobe as a command or a data write.
- Keeps a 128-byte shadow DDRAM plus display/entry state, and exposes them through a registered readback port.
- Used on-chip for self-check/mirroring (UART/VGA dump) and as a synthesizable bench responder.

Parameters:
SYNC_STAGES, 2, synchronizer depth on lcd_en/lcd_rs/lcd_wr/lcd_data (min 1)
RW_CHECK, 0, 0: every strobe is a write regardless of lcd_wr; 1: strobe accepted only if lcd_wr==0
FILL_CHAR, 8'h20, byte written to every cell by clear

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
lcd_en  in  1  LCD enable; falling edge = strobe
lcd_rs  in  1  0 = command, 1 = data
lcd_wr  in  1  R/W line; used only when RW_CHECK=1
lcd_data  in  8  LCD data bus
rd_addr  in  7  shadow DDRAM read address
rd_data  out  8  shadow DDRAM read data, 1-cycle latency
cur_addr  out  7  current DDRAM address counter
disp_on  out  1  display-on flag
cursor_on  out  1  cursor flag
blink_on  out  1  blink flag
busy  out  1  clear fill in progress
cmd_valid  out  1  1-cycle pulse per accepted strobe
cmd_rs  out  1  rs of accepted strobe
cmd_byte  out  8  data byte of accepted strobe
ovf  out  1  sticky: strobe lost while busy

Behaviour:
- Reset: clk and rst as already decided (reset rst, asynchronous, active-high; clock clk).
- Output values during reset: cur_addr=0, disp_on=0, cursor_on=0, blink_on=0, cmd_valid=0, cmd_rs=0, cmd_byte=0, ovf=0, rd_data=0. Internal increment flag inc=1, pending buffer empty.
- After reset the FSM sits in CLEAR with busy=1.
- Capture path:
  - All four bus inputs pass through SYNC_STAGES flops, then one edge register.
  - A strobe is detected when the synced en goes 1->0.
  - rs/data/wr are taken from the edge-register stage, i.e. the last cycle in which synced en was 1.
  - cmd_valid rises SYNC_STAGES+1 cycles after the pin falling edge.
- Sender timing requirement: en high >=1 clk and low >=1 clk when driven from clk; >=2 clk each otherwise. rs/data stable for the whole en-high period.
- Accepted strobe: cmd_valid=1 for one cycle with cmd_rs and cmd_byte. Its effects are visible from the next cycle.
- Data write (rs=1):
  - DDRAM[cur_addr] <= byte.
  - cur_addr +/-1 per inc, modulo 128 (0x7F->0x00 on increment, 0x00->0x7F on decrement).
- Command decode (rs=0), highest set bit wins:
  - 1aaaaaaa: cur_addr = aaaaaaa.
  - 01xxxxxx (CGRAM) and 001xxxxx (function set): no state change; cmd_valid still pulses.
  - 0001 S R xx: if S=0, cur_addr +1 (R=1) or -1 (R=0), mod 128; if S=1, no change.
  - 00001DCB: disp_on=D, cursor_on=C, blink_on=B.
  - 000001 I x: inc=I.
  - 0000001x: cur_addr=0.
  - 00000001: enter CLEAR.
  - 00000000: no-op.
- FSM states:
  - IDLE: executes strobes.
  - CLEAR: writes FILL_CHAR to one cell per cycle, cell 0 to cell 127 (128 cycles), busy=1. On exit: cur_addr=0, inc=1, return to IDLE. Display flags are unchanged.
- Strobe while busy:
  - Stored in a 1-deep pending register.
  - Executed in the first IDLE cycle; cmd_valid pulses at execution, not at capture.
  - A further strobe while pending is full is dropped and sets ovf=1. ovf is cleared only by rst.
  - A pending clear restarts a full 128-cycle CLEAR.
- Readback: rd_data <= DDRAM[rd_addr] every cycle. A same-cycle write to the same address returns the old value.
- Reset mid-CLEAR or mid-strobe: fill restarts at cell 0; pending buffer and synchronizer state are discarded.
- RW_CHECK=1 with lcd_wr=1 at capture: strobe ignored entirely (no cmd_valid, no ovf).

Optional Feature:
- Macro LCD_BUS_RX_FRAME_CNT_EN.
- Defined: extra output port frame_cnt (out, 8 bits).
  - Reset value 0.
  - Increments by 1 when a clear command executes (not when it is captured); wraps 255->0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Release rst, idle bus -> busy=1 for exactly 128 cycles then 0; rd_addr 0x00, 0x45, 0x7F -> rd_data=0x20; cur_addr=0.
2. Command 0x0C, then 0x0F -> after the first, disp_on=1, cursor_on=0, blink_on=0; after the second, all three =1; cmd_valid pulses twice with cmd_rs=0.
3. Data writes 0x32, 0x35, 0x2E, 0x30 -> DDRAM[0..3]=32,35,2E,30 and cur_addr=4; then 0xC0 + data 0x41 -> DDRAM[0x40]=0x41, cur_addr=0x41.
4. Command 0x80, 0x04, data 0x58, data 0x59 -> DDRAM[0x00]=0x58, DDRAM[0x7F]=0x59, cur_addr=0x7E.
5. Command 0x01, data 0x33 two cycles later -> the data executes on the first cycle after busy falls, DDRAM[0]=0x33, cur_addr=1, ovf=0. Repeat with two data strobes during busy -> ovf=1; only the first lands.
6. With LCD_BUS_RX_FRAME_CNT_EN defined, issue 257 clear commands -> frame_cnt=1. With RW_CHECK=1, a strobe with lcd_wr=1 -> no cmd_valid and no state change.

Source files
------------

// File: rtl/lcd_bus_rx.sv
// Receive-side snoop of an HD44780-style LCD bus: decodes en strobes into a shadow DDRAM
// plus display/entry state. Optional frame counter output when LCD_BUS_RX_FRAME_CNT_EN is defined.
module lcd_bus_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RW_CHECK    = 1'b0,
  parameter logic [7:0]  FILL_CHAR   = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_wr,
  input  logic [7:0] lcd_data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cur_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_byte,
`ifdef LCD_BUS_RX_FRAME_CNT_EN
  output logic [7:0] frame_cnt,
`endif
  output logic       ovf
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  typedef struct packed {
    logic       en;
    logic       rs;
    logic       wr;
    logic [7:0] data;
  } bus_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] dat;
  } strobe_t;

  bus_t    sync_q [SYNC_STAGES];
  bus_t    edge_q;
  logic    strobe, accept;
  strobe_t cap;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= {lcd_en, lcd_rs, lcd_wr, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // rs/data/wr come from the last cycle in which synced en was still high.
  assign strobe = edge_q.en & ~sync_q[SYNC_STAGES-1].en;
  assign accept = strobe & (~RW_CHECK | ~edge_q.wr);
  assign cap    = '{rs: edge_q.rs, dat: edge_q.data};

  state_t     state_q, state_n;
  logic [6:0] fill_q, fill_n;
  logic [6:0] cur_n;
  logic       disp_n, cursor_n, blink_n;
  logic       inc_q, inc_n;
  logic       pend_valid_q, pend_valid_n;
  strobe_t    pend_q, pend_n;
  logic       ovf_n;
  logic       cmd_valid_n, cmd_rs_n;
  logic [7:0] cmd_byte_n;
  logic       mem_we;
  logic [6:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       exec_en;
  strobe_t    exec;
`ifdef LCD_BUS_RX_FRAME_CNT_EN
  logic       frame_inc;
`endif

  assign busy = (state_q == S_CLEAR);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n      = state_q;
    fill_n       = fill_q;
    cur_n        = cur_addr;
    disp_n       = disp_on;
    cursor_n     = cursor_on;
    blink_n      = blink_on;
    inc_n        = inc_q;
    pend_valid_n = pend_valid_q;
    pend_n       = pend_q;
    ovf_n        = ovf;
    cmd_valid_n  = 1'b0;
    cmd_rs_n     = cmd_rs;
    cmd_byte_n   = cmd_byte;
    mem_we       = 1'b0;
    mem_waddr    = cur_addr;
    mem_wdata    = cap.dat;
    exec_en      = 1'b0;
    exec         = cap;
`ifdef LCD_BUS_RX_FRAME_CNT_EN
    frame_inc    = 1'b0;
`endif

    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = fill_q;
      mem_wdata = FILL_CHAR;
      fill_n    = fill_q + 7'd1;
      if (fill_q == 7'h7F) begin
        state_n = S_IDLE;
        cur_n   = '0;
        inc_n   = 1'b1;
      end
      if (accept) begin
        if (pend_valid_q) begin
          ovf_n = 1'b1;
        end else begin
          pend_valid_n = 1'b1;
          pend_n       = cap;
        end
      end
    end else begin
      // A parked strobe runs first; a strobe arriving in that same cycle takes its slot.
      exec_en = pend_valid_q | accept;
      exec    = pend_valid_q ? pend_q : cap;
      if (pend_valid_q) begin
        pend_valid_n = accept;
        if (accept) pend_n = cap;
      end
      if (exec_en) begin
        cmd_valid_n = 1'b1;
        cmd_rs_n    = exec.rs;
        cmd_byte_n  = exec.dat;
        if (exec.rs) begin
          mem_we    = 1'b1;
          mem_waddr = cur_addr;
          mem_wdata = exec.dat;
          cur_n     = inc_q ? cur_addr + 7'd1 : cur_addr - 7'd1;
        end else begin
          unique casez (exec.dat)
            8'b1???????: cur_n = exec.dat[6:0];
            8'b01??????,
            8'b001?????: ;
            8'b0001????: if (!exec.dat[3]) cur_n = exec.dat[2] ? cur_addr + 7'd1 : cur_addr - 7'd1;
            8'b00001???: begin
              disp_n   = exec.dat[2];
              cursor_n = exec.dat[1];
              blink_n  = exec.dat[0];
            end
            8'b000001??: inc_n = exec.dat[1];
            8'b0000001?: cur_n = '0;
            8'b00000001: begin
              state_n = S_CLEAR;
              fill_n  = '0;
`ifdef LCD_BUS_RX_FRAME_CNT_EN
              frame_inc = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      fill_q       <= '0;
      cur_addr     <= '0;
      disp_on      <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      inc_q        <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      ovf          <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_rs       <= 1'b0;
      cmd_byte     <= '0;
    end else begin
      state_q      <= state_n;
      fill_q       <= fill_n;
      cur_addr     <= cur_n;
      disp_on      <= disp_n;
      cursor_on    <= cursor_n;
      blink_on     <= blink_n;
      inc_q        <= inc_n;
      pend_valid_q <= pend_valid_n;
      pend_q       <= pend_n;
      ovf          <= ovf_n;
      cmd_valid    <= cmd_valid_n;
      cmd_rs       <= cmd_rs_n;
      cmd_byte     <= cmd_byte_n;
    end
  end

`ifdef LCD_BUS_RX_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt <= '0;
    else if (frame_inc) frame_cnt <= frame_cnt + 8'd1;
  end
`endif

  logic [7:0] mem [128];

  // NOTE: the DDRAM array has no reset so it maps to RAM; the CLEAR fill after reset initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Directed self-checking bench for lcd_bus_rx (RW_CHECK=1 instance; frame counter checks
// are compiled in when LCD_BUS_RX_FRAME_CNT_EN is defined).
module tb_lcd_bus_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_wr = 1'b0;
  logic [7:0] lcd_data = '0;
  logic [6:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [6:0] cur_addr;
  logic       disp_on, cursor_on, blink_on, busy;
  logic       cmd_valid, cmd_rs, ovf;
  logic [7:0] cmd_byte;
`ifdef LCD_BUS_RX_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  int passed = 0, failed = 0, total = 0;
  int pulses = 0;
  logic       last_rs;
  logic [7:0] last_byte;

  always #5 clk = ~clk;

  lcd_bus_rx #(.SYNC_STAGES(2), .RW_CHECK(1'b1), .FILL_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst),
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_wr(lcd_wr), .lcd_data(lcd_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cur_addr(cur_addr), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .busy(busy), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_byte(cmd_byte),
`ifdef LCD_BUS_RX_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .ovf(ovf)
  );

  always @(negedge clk) begin
    if (cmd_valid) begin
      pulses++;
      last_rs   = cmd_rs;
      last_byte = cmd_byte;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // en high 2 clk, then low; returns 4 clk after the falling edge (strobe executed if idle).
  task automatic strobe(input logic rs, input logic [7:0] d, input logic wr);
    @(negedge clk);
    lcd_rs = rs; lcd_data = d; lcd_wr = wr; lcd_en = 1'b1;
    repeat (2) @(negedge clk);
    lcd_en = 1'b0;
    repeat (4) @(negedge clk);
    lcd_wr = 1'b0;
  endtask

  task automatic read_mem(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  // Returns at the first negedge with busy low (or after the bound).
  task automatic wait_idle(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (busy && cycles < 400);
  endtask

  initial begin
    logic [7:0] d;
    int         c, p0, timeouts;

    // 1: reset state, 128-cycle fill, fill contents
    repeat (3) @(negedge clk);
    check("rst_cur_addr", cur_addr, 7'h00);
    check("rst_disp_on", disp_on, 1'b0);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_busy", busy, 1'b1);
    rst = 1'b0;
    wait_idle(c);
    check("fill_cycles", c, 128);
    read_mem(7'h00, d); check("fill_00", d, 8'h20);
    read_mem(7'h45, d); check("fill_45", d, 8'h20);
    read_mem(7'h7F, d); check("fill_7f", d, 8'h20);
    check("fill_cur_addr", cur_addr, 7'h00);

    // 2: display control
    p0 = pulses;
    strobe(1'b0, 8'h0C, 1'b0);
    check("dc1_disp", disp_on, 1'b1);
    check("dc1_cursor", cursor_on, 1'b0);
    check("dc1_blink", blink_on, 1'b0);
    strobe(1'b0, 8'h0F, 1'b0);
    check("dc2_flags", {disp_on, cursor_on, blink_on}, 3'b111);
    check("dc_pulses", pulses - p0, 2);
    check("dc_cmd_rs", last_rs, 1'b0);
    check("dc_cmd_byte", last_byte, 8'h0F);

    // 3: data writes and set-address
    strobe(1'b1, 8'h32, 1'b0);
    check("wr_cmd_rs", last_rs, 1'b1);
    strobe(1'b1, 8'h35, 1'b0);
    strobe(1'b1, 8'h2E, 1'b0);
    strobe(1'b1, 8'h30, 1'b0);
    read_mem(7'h00, d); check("wr_00", d, 8'h32);
    read_mem(7'h01, d); check("wr_01", d, 8'h35);
    read_mem(7'h02, d); check("wr_02", d, 8'h2E);
    read_mem(7'h03, d); check("wr_03", d, 8'h30);
    check("wr_cur_addr", cur_addr, 7'h04);
    strobe(1'b0, 8'hC0, 1'b0);
    check("setaddr_40", cur_addr, 7'h40);
    strobe(1'b1, 8'h41, 1'b0);
    read_mem(7'h40, d); check("wr_40", d, 8'h41);
    check("wr40_cur_addr", cur_addr, 7'h41);

    // 4: decrement mode with wrap below zero
    strobe(1'b0, 8'h80, 1'b0);
    check("setaddr_00", cur_addr, 7'h00);
    strobe(1'b0, 8'h04, 1'b0);
    strobe(1'b1, 8'h58, 1'b0);
    check("dec_wrap_addr", cur_addr, 7'h7F);
    strobe(1'b1, 8'h59, 1'b0);
    read_mem(7'h00, d); check("dec_00", d, 8'h58);
    read_mem(7'h7F, d); check("dec_7f", d, 8'h59);
    check("dec_cur_addr", cur_addr, 7'h7E);
    strobe(1'b0, 8'h14, 1'b0);
    check("shift_right", cur_addr, 7'h7F);
    strobe(1'b0, 8'h18, 1'b0);
    check("display_shift_nochg", cur_addr, 7'h7F);
    strobe(1'b0, 8'h06, 1'b0);
    strobe(1'b0, 8'h02, 1'b0);
    check("home", cur_addr, 7'h00);

    // 5: strobe during clear is parked and runs on the first idle cycle
    strobe(1'b0, 8'h01, 1'b0);
    check("clr_busy", busy, 1'b1);
    p0 = pulses;
    strobe(1'b1, 8'h33, 1'b0);
    check("pend_no_pulse", pulses - p0, 0);
    wait_idle(c);
    check("pend_idle_timeout", c < 400, 1'b1);
    check("pend_exit_addr", cur_addr, 7'h00);
    check("pend_exit_valid", cmd_valid, 1'b0);
    @(negedge clk);
    check("pend_exec_valid", cmd_valid, 1'b1);
    check("pend_exec_byte", cmd_byte, 8'h33);
    check("pend_exec_addr", cur_addr, 7'h01);
    read_mem(7'h00, d); check("pend_mem_00", d, 8'h33);
    read_mem(7'h05, d); check("clr_mem_05", d, 8'h20);
    check("pend_ovf", ovf, 1'b0);
    check("clr_flags_kept", {disp_on, cursor_on, blink_on}, 3'b111);

    strobe(1'b0, 8'h01, 1'b0);
    strobe(1'b1, 8'h44, 1'b0);
    strobe(1'b1, 8'h55, 1'b0);
    check("ovf_set", ovf, 1'b1);
    wait_idle(c);
    repeat (3) @(negedge clk);
    read_mem(7'h00, d); check("ovf_first_lands", d, 8'h44);
    read_mem(7'h01, d); check("ovf_second_dropped", d, 8'h20);
    check("ovf_cur_addr", cur_addr, 7'h01);

    // 6: RW_CHECK rejects reads
    p0 = pulses;
    strobe(1'b1, 8'h77, 1'b1);
    check("rw_no_pulse", pulses - p0, 0);
    check("rw_cur_addr", cur_addr, 7'h01);
    read_mem(7'h01, d); check("rw_mem_01", d, 8'h20);
    check("rw_ovf_kept", ovf, 1'b1);

`ifdef LCD_BUS_RX_FRAME_CNT_EN
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("frame_rst", frame_cnt, 8'h00);
    wait_idle(c);
    timeouts = 0;
    for (int i = 0; i < 257; i++) begin
      strobe(1'b0, 8'h01, 1'b0);
      wait_idle(c);
      if (c >= 400) timeouts++;
    end
    check("frame_timeouts", timeouts, 0);
    check("frame_wrap", frame_cnt, 8'h01);
`else
    timeouts = 0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
